// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the display-counter sequencer: counter width,
// sequence mode encodings and FSM state encoding.
package count_sequencer_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'b00,
    MODE_RUN_TO = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_STEP   = 2'b11
  } mode_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WAIT   = 3'd1;
  localparam state_t ST_PULSE  = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_FIN    = 3'd4;

endpackage

// File: rtl/count_sequencer_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and wraps, with a one-cycle tick
// on the last count. Also suitable as a debounce sample strobe.
module count_sequencer_tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Sequences an external up/down counter through run-to-target, bounce and
// single-step programs by pulsing its enable at a prescaled step rate.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int N   = CNT_W,
  parameter int DIV = 50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic [1:0]   mode_i,
  input  logic         dir_i,
  input  logic [N-1:0] target_i,
  input  logic [N-1:0] lo_i,
  input  logic [N-1:0] hi_i,
  input  logic [N-1:0] cnt_val_i,
  output logic         cnt_en_o,
  output logic         cnt_up_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [2:0]   state_o
);

  state_t       state_q, state_d;
  mode_e        mode_q, mode_d;
  logic [N-1:0] target_q, target_d, lo_q, lo_d, hi_q, hi_d;
  logic         first_q, first_d;
  logic         cnt_en_q, cnt_up_q, up_d;
  logic         tick, tick_clr, start_ok;
  logic         eval_term, eval_up;

  // start is a request taken only in IDLE; stop wins over start and aborts
  // any state on the next edge without a done pulse.
  assign start_ok = start_i && !stop_i && (mode_i != MODE_NONE);

  count_sequencer_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tick_clr),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  // Terminal test and next direction from the current counter feedback.
  always_comb begin
    eval_term = 1'b1;
    eval_up   = cnt_up_q;
    case (mode_q)
      MODE_RUN_TO: begin
        eval_term = (cnt_val_i == target_q);
        eval_up   = (target_q > cnt_val_i);
      end
      MODE_BOUNCE: begin
        eval_term = (lo_q >= hi_q);
        if (first_q)                 eval_up = (cnt_val_i < hi_q);
        else if (cnt_val_i >= hi_q)  eval_up = 1'b0;
        else if (cnt_val_i <= lo_q)  eval_up = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    target_d = target_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    first_d  = first_q;
    up_d     = cnt_up_q;
    tick_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          mode_d   = mode_e'(mode_i);
          target_d = target_i;
          lo_d     = lo_i;
          hi_d     = hi_i;
          first_d  = 1'b1;
          tick_clr = 1'b1;
          if (mode_i == MODE_STEP) begin
            up_d    = dir_i;
            state_d = ST_PULSE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        first_d = 1'b0;
        if (first_q && eval_term) begin
          state_d = ST_FIN;
        end else begin
          if (first_q) up_d = eval_up;
          if (tick)    state_d = ST_PULSE;
        end
      end
      ST_PULSE:  state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (eval_term) begin
          state_d = ST_FIN;
        end else begin
          up_d    = eval_up;
          state_d = ST_WAIT;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (stop_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_NONE;
      target_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      first_q  <= 1'b0;
      cnt_en_q <= 1'b0;
      cnt_up_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      first_q  <= first_d;
      cnt_en_q <= (state_d == ST_PULSE);
      cnt_up_q <= up_d;
    end
  end

  assign cnt_en_o = cnt_en_q;
  assign cnt_up_o = cnt_up_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = (state_q == ST_FIN);
  assign state_o  = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer with DIV=4 driving an 8-bit up/down counter that
// lives in the bench; expected waveforms come from a cycle-table model.
module tb_count_sequencer;

  localparam int N   = 8;
  localparam int DIV = 4;
  localparam int LEN = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0, stop = 1'b0, dir = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [N-1:0] target = '0, lo = '0, hi = '0;
  logic [N-1:0] cnt_val = '0;
  logic         cnt_en, cnt_up, busy, done;
  logic [2:0]   state_dbg;

  count_sequencer #(.N(N), .DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .stop_i    (stop),
    .mode_i    (mode),
    .dir_i     (dir),
    .target_i  (target),
    .lo_i      (lo),
    .hi_i      (hi),
    .cnt_val_i (cnt_val),
    .cnt_en_o  (cnt_en),
    .cnt_up_o  (cnt_up),
    .busy_o    (busy),
    .done_o    (done),
    .state_o   (state_dbg)
  );

  // Display counter: loadable, steps on cnt_en, untouched by rst.
  logic         ld = 1'b0;
  logic [N-1:0] ld_v = '0;
  always @(posedge clk) begin
    if (ld)          cnt_val <= ld_v;
    else if (cnt_en) cnt_val <= cnt_up ? cnt_val + 8'd1 : cnt_val - 8'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errs   = 0;
  int base     = 0;
  int win      = 0;
  bit chk_on   = 1'b0;
  int ck;
  bit pulse_prev;

  bit           exp_en[LEN], exp_busy[LEN], exp_done[LEN], exp_care[LEN], exp_up[LEN];
  logic [N-1:0] exp_cnt[LEN];
  logic [N-1:0] exp_final;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      ck = cyc - base;
      if (ck >= 1 && ck <= win && ck < LEN) begin
        check("busy",    ck, 32'(busy),    32'(exp_busy[ck]));
        check("cnt_en",  ck, 32'(cnt_en),  32'(exp_en[ck]));
        check("done",    ck, 32'(done),    32'(exp_done[ck]));
        check("cnt_val", ck, 32'(cnt_val), 32'(exp_cnt[ck]));
        if (exp_care[ck]) check("cnt_up", ck, 32'(cnt_up), 32'(exp_up[ck]));
        if (pulse_prev) begin
          logic [N-1:0] e;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          check("count_after_pulse", ck, 32'(cnt_val), 32'(e));
        end
        pulse_prev = cnt_en;
      end
    end
  end

  // Model: pulses every DIV cycles from DIV+1, directions from the mode rules,
  // done two cycles after the terminal pulse; cycle 0 is the start cycle.
  task automatic plan(input logic [1:0] m, input bit d, input logic [N-1:0] tgt, l, h, c0,
                      input bit ignore, input int stop_at, input int w);
    logic [N-1:0] c;
    bit up;
    int last, pc;
    for (int i = 0; i < LEN; i++) begin
      exp_en[i] = 0; exp_busy[i] = 0; exp_done[i] = 0; exp_care[i] = 0; exp_up[i] = 0;
      exp_cnt[i] = c0;
    end
    exp_q.delete();
    win  = w;
    c    = c0;
    last = 0;
    if (!ignore) begin
      if (m == 2'b11) begin
        exp_en[1] = 1; exp_care[1] = 1; exp_up[1] = d;
        c = d ? c + 8'd1 : c - 8'd1;
        exp_q.push_back(c);
        for (int i = 2; i < LEN; i++) exp_cnt[i] = c;
        last = 3;
      end else if ((m == 2'b01 && c0 == tgt) || (m == 2'b10 && l >= h)) begin
        last = 2;
      end else begin
        up = (m == 2'b01) ? (tgt > c) : (c < h);
        for (int j = 1; j * DIV + 1 < LEN && last == 0; j++) begin
          pc = j * DIV + 1;
          if (stop_at > 0 && pc > stop_at) break;
          exp_en[pc] = 1; exp_care[pc] = 1; exp_up[pc] = up;
          c = up ? c + 8'd1 : c - 8'd1;
          exp_q.push_back(c);
          for (int i = pc + 1; i < LEN; i++) exp_cnt[i] = c;
          if (m == 2'b01) begin
            if (c == tgt) last = pc + 2;
            else          up = (tgt > c);
          end else begin
            if (c == h)      up = 0;
            else if (c == l) up = 1;
            else if (c > h)  up = 0;
            else if (c < l)  up = 1;
          end
        end
      end
      if (last > 0) begin
        exp_done[last] = 1;
        for (int i = 1; i <= last; i++) exp_busy[i] = 1;
      end else begin
        for (int i = 1; i <= stop_at; i++) exp_busy[i] = 1;
      end
    end
    exp_final = c;
  endtask

  // ---------------- driver tasks ----------------
  task automatic goto_cycle(input int k);
    while (cyc - base < k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic preset(input logic [N-1:0] v);
    @(posedge clk); #1;
    ld = 1'b1; ld_v = v;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  task automatic run_scn(input logic [1:0] m, input bit d, input logic [N-1:0] tgt, l, h, c0,
                         input bit together, input int stop_at, input int poke_at, input int w);
    preset(c0);
    plan(m, d, tgt, l, h, c0, together || (m == 2'b00), stop_at, w);
    mode = m; dir = d; target = tgt; lo = l; hi = h;
    start = 1'b1; stop = together;
    base = cyc; pulse_prev = 0; chk_on = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    // Scramble the programming inputs; the sequence must use latched copies.
    mode = 2'($urandom_range(0, 3)); dir = 1'($urandom_range(0, 1));
    target = 8'($urandom_range(0, 255)); lo = 8'($urandom_range(0, 255)); hi = 8'($urandom_range(0, 255));
    if (poke_at > 0) begin
      goto_cycle(poke_at);
      start = 1'b1; mode = 2'b11;
      goto_cycle(poke_at + 1);
      start = 1'b0;
    end
    if (stop_at > 0) begin
      goto_cycle(stop_at);
      stop = 1'b1;
      goto_cycle(stop_at + 1);
      stop = 1'b0;
    end
    goto_cycle(w);
    @(negedge clk); #1;
    chk_on = 1'b0;
    check("pulses_left", w, 32'(exp_q.size()), 32'd0);
    check("final_cnt",   w, 32'(cnt_val),      32'(exp_final));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   0, 32'(busy),   32'd0);
    check("rst_cnt_en", 0, 32'(cnt_en), 32'd0);
    check("rst_cnt_up", 0, 32'(cnt_up), 32'd1);
    check("rst_done",   0, 32'(done),   32'd0);
    rst = 1'b1;

    // Pin the model against hand-derived timings.
    plan(2'b01, 0, 8'h03, 8'h00, 8'h00, 8'h00, 0, 0, 20);
    check("pin_run_pulse5",  5,  32'(exp_en[5]),   32'd1);
    check("pin_run_pulse9",  9,  32'(exp_en[9]),   32'd1);
    check("pin_run_pulse13", 13, 32'(exp_en[13]),  32'd1);
    check("pin_run_done15",  15, 32'(exp_done[15]), 32'd1);
    check("pin_run_busy16",  16, 32'(exp_busy[16]), 32'd0);
    check("pin_run_final",   0,  32'(exp_final),   32'h03);
    plan(2'b01, 0, 8'h02, 8'h00, 8'h00, 8'h05, 0, 0, 20);
    check("pin_down_up5",    5,  32'(exp_up[5]),   32'd0);
    check("pin_down_final",  0,  32'(exp_final),   32'h02);
    plan(2'b10, 0, 8'h00, 8'h01, 8'h03, 8'h00, 0, 26, 34);
    check("pin_bounce_final", 0, 32'(exp_final),    32'h02);
    check("pin_bounce_busy26", 26, 32'(exp_busy[26]), 32'd1);
    check("pin_bounce_busy27", 27, 32'(exp_busy[27]), 32'd0);
    plan(2'b10, 0, 8'h00, 8'h05, 8'h05, 8'h00, 0, 0, 8);
    s = 0;
    for (int i = 0; i < LEN; i++) s += int'(exp_en[i]);
    check("pin_equal_nopulse", 0, 32'(s), 32'd0);
    check("pin_equal_done2",   2, 32'(exp_done[2]), 32'd1);
    plan(2'b11, 1, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0, 8);
    check("pin_step_pulse1", 1, 32'(exp_en[1]),   32'd1);
    check("pin_step_done3",  3, 32'(exp_done[3]), 32'd1);
    check("pin_step_final",  0, 32'(exp_final),   32'h00);

    //      mode   dir tgt    lo     hi     c0     tog stop poke win
    run_scn(2'b01, 0, 8'h03, 8'h00, 8'h00, 8'h00, 0,  0,   7,  20);
    run_scn(2'b01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,  0,   0,   8);
    run_scn(2'b01, 0, 8'h02, 8'h00, 8'h00, 8'h05, 0,  0,   0,  20);
    run_scn(2'b10, 0, 8'h00, 8'h01, 8'h03, 8'h00, 0,  26,  0,  34);
    run_scn(2'b10, 0, 8'h00, 8'h05, 8'h05, 8'h00, 0,  0,   0,   8);
    run_scn(2'b11, 1, 8'h00, 8'h00, 8'h00, 8'hFF, 0,  0,   0,   8);
    run_scn(2'b11, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,  0,   0,   8);
    run_scn(2'b10, 0, 8'h00, 8'h02, 8'h04, 8'h06, 0,  20,  0,  26);
    run_scn(2'b01, 0, 8'h03, 8'h00, 8'h00, 8'h00, 1,  0,   0,  10);
    run_scn(2'b00, 1, 8'h03, 8'h00, 8'h00, 8'h00, 0,  0,   0,  10);

    // Asynchronous reset in the middle of a WAIT period.
    preset(8'h07);
    mode = 2'b01; target = 8'h20; start = 1'b1; base = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    goto_cycle(3);
    check("pre_rst_busy", 3, 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy",   3, 32'(busy),   32'd0);
    check("async_rst_cnt_en", 3, 32'(cnt_en), 32'd0);
    check("async_rst_cnt_up", 3, 32'(cnt_up), 32'd1);
    check("async_rst_done",   3, 32'(done),   32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    goto_cycle(12);
    check("post_rst_busy", 12, 32'(busy),    32'd0);
    check("post_rst_cnt",  12, 32'(cnt_val), 32'h07);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Controller that sequences the shared N-bit up/down display counter: it drives the counter's enable and direction inputs, reads back the count, and runs one of three programmed sequences (run-to-target, bounce between limits, single step) at a prescaled step rate. It sits between the board switches/keys and the counter, replacing direct switch control of enable/direction. It owns no count state of its own.

## Interface
- N, 8: counter width.
- DIV, 50_000_000: clk cycles per step; legal range ≥ 3.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin sequence; sampled only in IDLE.
- stop  in  1  synchronous abort; has priority over start.
- mode  in  2  00 none, 01 RUN_TO, 10 BOUNCE, 11 STEP; latched on start.
- dir  in  1  STEP direction (1 up); latched on start.
- target  in  N  RUN_TO end value; latched on start.
- lo, hi  in  N each  BOUNCE limits; latched on start.
- cnt_val  in  N  counter feedback; must reflect a cnt_en pulse one cycle later.
- cnt_en  out  1  one-cycle counter enable pulse, registered.
- cnt_up  out  1  counter direction (1 = +1, 0 = −1), registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, WAIT, PULSE, SETTLE, FIN.
- IDLE: start=1, stop=0, mode≠00 → latch mode/dir/target/lo/hi, clear prescaler. Next state is PULSE for STEP, WAIT otherwise. Mode 00 leaves start ignored.
- WAIT: prescaler counts 0..DIV−1 and wraps. At p==DIV−1 → PULSE.
- PULSE: cnt_en=1 for exactly one cycle, with cnt_up valid that cycle → SETTLE.
- SETTLE: evaluate cnt_val.
  - Terminal → FIN.
  - Otherwise update direction → WAIT.
- FIN: done=1 for one cycle → IDLE.
- RUN_TO:
  - Initial evaluation happens in the first WAIT cycle. If cnt_val==target → FIN with no pulse.
  - Otherwise cnt_up = (target > cnt_val), unsigned compare with no wrap shortcut.
  - Terminal when cnt_val==target.
- BOUNCE:
  - lo ≥ hi → FIN with no pulse.
  - Otherwise up when cnt_val<hi, down when cnt_val≥hi.
  - At cnt_val==hi flip to down; at cnt_val==lo flip to up.
  - Outside [lo,hi], move toward the range; no flip until a limit is reached.
  - Never terminal; runs until stop.
- STEP: one pulse with cnt_up=dir, then SETTLE → FIN. The counter's own wrap (FF+1→00) is accepted.
- stop=1 in any state:
  - Next state IDLE; cnt_en=0 from the next cycle; no done pulse.
  - A PULSE already in progress completes its single cycle.
- start while busy: ignored. start and stop together in IDLE: stay IDLE.

## Timing
- Reset values: cnt_en=0, cnt_up=1, busy=0, done=0, state IDLE, prescaler 0, latched regs 0.
- Cycle numbering: start sampled at edge 0; "cycle k" is the cycle after edge k.
- WAIT modes:
  - busy=1 from cycle 1.
  - Prescaler free-runs while busy, so the step period is exactly DIV cycles.
  - Pulses occur at cycles DIV+1, 2·DIV+1, …
- Terminal SETTLE at cycle m·DIV+2 → done at m·DIV+3 → busy=0 at m·DIV+4.
- STEP: pulse cycle 1, SETTLE cycle 2, done cycle 3, busy=0 cycle 4.
- Immediate finish (RUN_TO already at target, or BOUNCE lo≥hi): done at cycle 2.
- Reset mid-sequence: all outputs return to reset values immediately (asynchronous); the counter is not touched.

## Structure
- Shared package:
  - mode encodings (MODE_NONE/RUN_TO/BOUNCE/STEP);
  - state enum;
  - width parameter N shared with the counter.
- Sub-module tick_gen:
  - DIV prescaler with clear, enable, and one-cycle tick at DIV−1;
  - also reusable for debounce.

## Test plan
All scenarios use N=8, DIV=4, with the real counter instantiated and reset to 0x00.
- RUN_TO target=0x03 → pulses with cnt_up=1 at cycles 5, 9, 13; done at 15; cnt_val=0x03; busy low at 16.
- RUN_TO target equal to cnt_val (0x00) → no pulse; done at cycle 2.
- Preset count 0x05; RUN_TO target=0x02 → three pulses with cnt_up=0; final 0x02.
- BOUNCE lo=0x01, hi=0x03 from 0x00 → count sequence 01, 02, 03, 02, 01, 02…; stop after 6 pulses → busy=0 next cycle, no done, count frozen.
- BOUNCE lo=0x05, hi=0x05 → done at cycle 2, no pulse.
- Preset count 0xFF; STEP dir=1 → one pulse at cycle 1; count 0x00; done at cycle 3.
- Corner cases:
  - start asserted while busy → no effect on the sequence.
  - start+stop together in IDLE → remains IDLE.
  - rst low during WAIT → busy=0 and cnt_en=0 at once.
